// File: rtl/mac3_sequencer.sv
// Control sequencer for a three-lane MAC: fetches operand triples, groups num_steps fires into one
// accumulator result and holds each result until the consumer accepts it.
module mac3_sequencer #(
    parameter int unsigned STEP_W = 8,
    parameter int unsigned OUT_W  = 8
) (
    input  logic              clk,
    input  logic              arst_n_in,
    input  logic              start,
    input  logic [STEP_W-1:0] cfg_num_steps,
    input  logic [OUT_W-1:0]  cfg_num_outputs,
    input  logic              cfg_use_psum,
    output logic              busy,
    output logic              done,
    input  logic              op_valid,
    output logic              op_ready,
    output logic              mac_input_valid,
    output logic              mac_accumulate_internal,
    output logic              mac_psum_en,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUT_W-1:0]  res_index
);

    typedef enum logic [1:0] {StIdle, StRun, StResult} state_e;

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [STEP_W-1:0] num_steps_q, num_steps_d;
    logic [OUT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [OUT_W-1:0]  num_outputs_q, num_outputs_d;
    logic              use_psum_q, use_psum_d;
    logic              done_q, done_d;
    logic              fire;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q       <= StIdle;
            step_cnt_q    <= '0;
            num_steps_q   <= '0;
            out_cnt_q     <= '0;
            num_outputs_q <= '0;
            use_psum_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_cnt_q    <= step_cnt_d;
            num_steps_q   <= num_steps_d;
            out_cnt_q     <= out_cnt_d;
            num_outputs_q <= num_outputs_d;
            use_psum_q    <= use_psum_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        step_cnt_d    = step_cnt_q;
        num_steps_d   = num_steps_q;
        out_cnt_d     = out_cnt_q;
        num_outputs_d = num_outputs_q;
        use_psum_d    = use_psum_q;
        done_d        = 1'b0;
        op_ready      = (state_q == StRun);
        fire          = op_valid && op_ready;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_steps_d   = cfg_num_steps;
                    num_outputs_d = cfg_num_outputs;
                    use_psum_d    = cfg_use_psum;
                    step_cnt_d    = '0;
                    out_cnt_d     = '0;
                    // An empty job finishes immediately without touching the MAC.
                    if (cfg_num_steps == '0 || cfg_num_outputs == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (fire) begin
                    if (step_cnt_q == num_steps_q - STEP_W'(1)) begin
                        step_cnt_d = '0;
                        state_d    = StResult;
                    end else begin
                        step_cnt_d = step_cnt_q + STEP_W'(1);
                    end
                end
            end
            StResult: begin
                if (res_ready) begin
                    out_cnt_d = out_cnt_q + OUT_W'(1);
                    if (out_cnt_q == num_outputs_q - OUT_W'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mac_input_valid         = fire;
    assign mac_accumulate_internal = (step_cnt_q != '0);
    assign mac_psum_en             = use_psum_q && (step_cnt_q == '0);
    assign res_valid               = (state_q == StResult);
    assign res_index               = out_cnt_q;
    assign busy                    = (state_q != StIdle);
    assign done                    = done_q;

endmodule

// File: tb/tb_mac3_sequencer.sv
// Directed-plus-random bench for mac3_sequencer; a bench-side MAC driven by the DUT controls is
// compared with the plain sum of products that each output should produce.
module tb_mac3_sequencer;

    logic       clk = 1'b0;
    logic       arst_n_in = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cfg_num_steps = '0;
    logic [7:0] cfg_num_outputs = '0;
    logic       cfg_use_psum = 1'b0;
    logic       busy, done, op_ready, mac_input_valid, mac_accumulate_internal, mac_psum_en;
    logic       res_valid;
    logic       op_valid = 1'b0;
    logic       res_ready = 1'b0;
    logic [7:0] res_index;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [7:0]  a0, a1, a2, b0, b1, b2;
    logic [15:0] psum;
    logic [31:0] acc;
    logic [6:0]  toggle_pat;

    mac3_sequencer #(.STEP_W(8), .OUT_W(8)) dut (
        .clk                     (clk),
        .arst_n_in               (arst_n_in),
        .start                   (start),
        .cfg_num_steps           (cfg_num_steps),
        .cfg_num_outputs         (cfg_num_outputs),
        .cfg_use_psum            (cfg_use_psum),
        .busy                    (busy),
        .done                    (done),
        .op_valid                (op_valid),
        .op_ready                (op_ready),
        .mac_input_valid         (mac_input_valid),
        .mac_accumulate_internal (mac_accumulate_internal),
        .mac_psum_en             (mac_psum_en),
        .res_valid               (res_valid),
        .res_ready               (res_ready),
        .res_index               (res_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ops();
        a0 = 8'($urandom); a1 = 8'($urandom); a2 = 8'($urandom);
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
    endtask

    function automatic logic [31:0] prod_sum();
        return 32'(a0) * 32'(b0) + 32'(a1) * 32'(b1) + 32'(a2) * 32'(b2);
    endfunction

    // Glue + MAC: restart from psum (or zero) unless accumulating, write only when enabled.
    task automatic mac_update();
        if (mac_input_valid === 1'b1)
            acc = (mac_accumulate_internal ? acc : (mac_psum_en ? 32'(psum) : 32'd0)) + prod_sum();
    endtask

    task automatic run_job(input int steps, input int outs, input bit use_psum, input int vmode,
                           input int stall_out, input int stall_len, input bit in_done_cycle);
        int          fires, budget, k, vcnt;
        logic [31:0] exp;
        vcnt = 0;
        @(negedge clk);
        start = 1'b1;
        cfg_num_steps = 8'(steps);
        cfg_num_outputs = 8'(outs);
        cfg_use_psum = use_psum;
        op_valid = 1'b1;
        res_ready = 1'b1;
        set_ops();
        #1;
        check("start_busy", 32'(busy), 32'd0);
        check("start_op_ready", 32'(op_ready), 32'd0);
        check("start_mac_valid", 32'(mac_input_valid), 32'd0);
        check("start_done", 32'(done), 32'(in_done_cycle));
        for (int o = 0; o < outs; o++) begin
            psum = 16'($urandom);
            exp = use_psum ? 32'(psum) : 32'd0;
            fires = 0;
            budget = 0;
            while (fires < steps && budget < 200) begin
                @(negedge clk);
                start = 1'($urandom_range(0, 1));
                cfg_num_steps = 8'($urandom);
                cfg_num_outputs = 8'($urandom);
                cfg_use_psum = 1'($urandom_range(0, 1));
                if (vmode == 0) op_valid = 1'b1;
                else if (vmode == 1) op_valid = 1'($urandom_range(0, 1));
                else op_valid = toggle_pat[vcnt % 7];
                vcnt++;
                res_ready = 1'($urandom_range(0, 1));
                set_ops();
                #1;
                check("run_op_ready", 32'(op_ready), 32'd1);
                check("run_res_valid", 32'(res_valid), 32'd0);
                check("run_index", 32'(res_index), 32'(o));
                check("run_busy", 32'(busy), 32'd1);
                check("mac_valid", 32'(mac_input_valid), 32'(op_valid));
                if (op_valid) begin
                    check("acc_internal", 32'(mac_accumulate_internal), 32'(fires != 0));
                    check("psum_en", 32'(mac_psum_en), 32'(use_psum && fires == 0));
                    exp += prod_sum();
                    fires++;
                end
                mac_update();
                budget++;
            end
            check("fire_count", 32'(fires), 32'(steps));
            k = 0;
            do begin
                @(negedge clk);
                start = 1'($urandom_range(0, 1));
                op_valid = 1'($urandom_range(0, 1));
                set_ops();
                if (o == stall_out && k < stall_len) res_ready = 1'b0;
                else if (vmode == 1) res_ready = 1'($urandom_range(0, 1));
                else res_ready = 1'b1;
                #1;
                check("res_valid", 32'(res_valid), 32'd1);
                check("res_op_ready", 32'(op_ready), 32'd0);
                check("res_mac_valid", 32'(mac_input_valid), 32'd0);
                check("res_index", 32'(res_index), 32'(o));
                check("res_busy", 32'(busy), 32'd1);
                check("res_done", 32'(done), 32'd0);
                check("result_value", acc, exp);
                mac_update();
                k++;
            end while (!res_ready && k < 200);
        end
    endtask

    task automatic finish_job();
        @(negedge clk);
        start = 1'b0;
        op_valid = 1'b1;
        res_ready = 1'b1;
        #1;
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_op_ready", 32'(op_ready), 32'd0);
        check("done_res_valid", 32'(res_valid), 32'd0);
        check("done_mac_valid", 32'(mac_input_valid), 32'd0);
        @(negedge clk);
        #1;
        check("done_single", 32'(done), 32'd0);
    endtask

    initial begin
        toggle_pat = 7'b1011001;  // op_valid sequence 1,0,0,1,1,0,1 read from bit 0 upward
        acc = $urandom;
        set_ops();
        psum = '0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_op_ready", 32'(op_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_index", 32'(res_index), 32'd0);
        check("rst_mac_valid", 32'(mac_input_valid), 32'd0);
        @(negedge clk);
        arst_n_in = 1'b1;

        run_job(3, 1, 1'b0, 0, -1, 0, 1'b0);
        finish_job();

        run_job(2, 3, 1'b1, 0, 1, 4, 1'b0);
        finish_job();

        run_job(4, 2, 1'b1, 2, -1, 0, 1'b0);
        // Back-to-back start in the done cycle.
        run_job(1, 2, 1'b0, 0, 0, 2, 1'b1);
        finish_job();

        // Zero config: done on the next cycle, which also accepts the following start.
        @(negedge clk);
        start = 1'b1;
        cfg_num_steps = 8'd0;
        cfg_num_outputs = 8'd5;
        cfg_use_psum = 1'b1;
        op_valid = 1'b1;
        #1;
        check("zero_busy", 32'(busy), 32'd0);
        run_job(2, 1, 1'b1, 0, -1, 0, 1'b1);
        finish_job();

        // Abort a steps=5 job after two fires.
        @(negedge clk);
        start = 1'b1;
        cfg_num_steps = 8'd5;
        cfg_num_outputs = 8'd1;
        cfg_use_psum = 1'b0;
        op_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            start = 1'b0;
            op_valid = 1'b1;
            set_ops();
            #1;
            mac_update();
        end
        @(negedge clk);
        #2;
        arst_n_in = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_op_ready", 32'(op_ready), 32'd0);
        check("arst_mac_valid", 32'(mac_input_valid), 32'd0);
        check("arst_acc_internal", 32'(mac_accumulate_internal), 32'd0);
        check("arst_res_valid", 32'(res_valid), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_res_index", 32'(res_index), 32'd0);
        @(negedge clk);
        #1;
        arst_n_in = 1'b1;
        run_job(5, 1, 1'b0, 0, -1, 0, 1'b0);
        finish_job();

        for (int j = 0; j < 6; j++) begin
            run_job(int'($urandom_range(1, 6)), int'($urandom_range(1, 3)),
                    1'($urandom_range(0, 1)), 1, int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), 1'b0);
            finish_job();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mac3_sequencer.md
# mac3_sequencer

Control sequencer for one three-lane MAC datapath. It fetches operand triples from an upstream feeder and drives the MAC write-enable and accumulate-select controls. It groups a configurable number of steps into one output, then holds each finished accumulator value until a downstream consumer accepts it. It sits between the operand feeder / partial-sum buffer and the MAC, one instance per MAC.

## Interface
- STEP_W, 8, width of steps-per-output count
- OUT_W, 8, width of outputs-per-job count and result index
- clk  in  1  clock, all state on rising edge
- arst_n_in  in  1  asynchronous active-low reset
- start  in  1  job start; sampled only when state is IDLE
- cfg_num_steps  in  STEP_W  MAC steps per output; latched on accepted start
- cfg_num_outputs  in  OUT_W  outputs per job; latched on accepted start
- cfg_use_psum  in  1  first step of each output adds external partial sum (1) or zero (0); latched on accepted start
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- op_valid  in  1  feeder has an operand triple
- op_ready  out  1  sequencer accepts a triple this cycle
- mac_input_valid  out  1  MAC accumulator write enable
- mac_accumulate_internal  out  1  0 = restart from partial sum, 1 = accumulate
- mac_psum_en  out  1  1 = pass partial_sum_in to MAC, 0 = glue forces it to zero
- res_valid  out  1  MAC output holds a finished result
- res_ready  in  1  consumer accepts result
- res_index  out  OUT_W  index of the output currently being computed or presented

## Operation
- States: IDLE, RUN, RESULT.
  - IDLE: start=1 latches the cfg values, clears step_cnt and out_cnt, and goes to RUN.
  - IDLE with zero config: if either latched count is 0, the block goes to IDLE with done=1 next cycle; no fires occur.
  - RUN: fire = op_valid && op_ready. Each fire increments step_cnt.
    - Fire with step_cnt == num_steps-1: go to RESULT and reset step_cnt to 0.
  - RESULT: res_valid=1. On res_ready, increment out_cnt.
    - If out_cnt was num_outputs-1: go to IDLE with done=1.
    - Otherwise: go to RUN.
- op_ready = (state == RUN). It is never high in RESULT, so the finished accumulator is not overwritten.
- mac_input_valid = fire (combinational). It is the only MAC write enable.
- mac_accumulate_internal = (step_cnt != 0); it is meaningful only on fire cycles.
- mac_psum_en = latched cfg_use_psum && step_cnt == 0. Outside the first step it is 0.
- res_index = out_cnt. It increments on each result handshake and is 0 at job start.
- busy = (state != IDLE).
- done is registered: it is high for exactly one cycle, in the first IDLE cycle after the final handshake. start is accepted in that same cycle.
- start while busy is ignored. cfg inputs change freely after start is accepted.
- op_valid may drop at any time in RUN; the block stalls and holds its counters.
- Counters are unsigned. num_steps up to 2^STEP_W-1 and num_outputs up to 2^OUT_W-1 complete without wrap.

## Timing
- Reset (asynchronous, any state, including mid-job): state=IDLE, counters=0, latched cfg=0. Outputs: busy=0, done=0, op_ready=0, res_valid=0, res_index=0, mac_input_valid=0.
  - The MAC accumulator is not cleared by this block. The next job restarts it with accumulate_internal=0.
- Start accepted at cycle t: op_ready=1 from t+1.
- Last fire at cycle t: the accumulator is written at the end of t; res_valid=1 from t+1.
- Result handshake at cycle u:
  - more outputs remain: op_ready=1 at u+1;
  - final output: done=1 and busy=0 at u+1.
- Minimum cycles per output = num_steps + 1, with continuous op_valid and res_ready.
- Zero-config start at t: done=1 at t+1, busy=0 at t+1.
- res_valid stays high and res_index is stable until res_ready is seen.

## Test plan
- Steps=3, outputs=1, use_psum=0, op_valid held 1, res_ready held 1. Required response:
  - mac_input_valid high for 3 cycles, with accumulate_internal 0,1,1 and psum_en 1→0 pattern = 0,0,0.
  - res_valid one cycle, then done one cycle later.
  - MAC out equals the sum of the 9 products.
- Steps=2, outputs=3, use_psum=1, res_ready held 0 for 4 cycles on output 1. Required response:
  - op_ready=0 throughout the stall; res_index=1 stable.
  - The accumulator value does not change during the stall.
  - res_index sequence is 0,1,2, then done.
- Steps=4, op_valid toggling 1,0,0,1,1,0,1. Required response:
  - exactly 4 fires, res_valid on the cycle after the 4th fire;
  - accumulate_internal=0 only on the first fire.
- Start pulsed again while busy, plus a zero config (steps=0, outputs=5). Required response:
  - the second start is ignored;
  - the zero config gives done at t+1 with no fires;
  - back-to-back start in the done cycle is accepted.
- Reset asserted mid-RUN at step 2 of 5. Required response:
  - all outputs 0 immediately (asynchronous);
  - after release, a new job with steps=5 produces a correct fresh sum with no residue from the aborted job.
